// File: rtl/palette_pkg.sv
// Palette constants and helpers: xterm system colours, cube levels, FSM states, rgb type.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a.
package palette_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } palette_state_e;

  // One palette colour at full 8-bit channel precision, packed {R,G,B}.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  // xterm colours 0..15.
  localparam logic [23:0] SYS_COLOURS [16] = '{
    24'h000000, 24'h800000, 24'h008000, 24'h808000,
    24'h000080, 24'h800080, 24'h008080, 24'hc0c0c0,
    24'h808080, 24'hff0000, 24'h00ff00, 24'hffff00,
    24'h0000ff, 24'hff00ff, 24'h00ffff, 24'hffffff
  };

  // Per-channel intensity steps of the 6x6x6 colour cube.
  localparam logic [7:0] CUBE_LVL [6] = '{
    8'h00, 8'h5f, 8'h87, 8'haf, 8'hd7, 8'hff
  };

  // Default table entry for an index; indices past the xterm range are black.
  function automatic rgb8_t xterm_rgb8(input logic [9:0] idx);
    rgb8_t      c;
    logic [7:0] k;
    logic [7:0] grey;
    c    = '0;
    k    = '0;
    grey = '0;
    if (idx < 10'd16) begin
      c = rgb8_t'(SYS_COLOURS[idx[3:0]]);
    end else if (idx < 10'd232) begin
      k   = idx[7:0] - 8'd16;
      c.r = CUBE_LVL[3'(k / 8'd36)];
      c.g = CUBE_LVL[3'((k / 8'd6) % 8'd6)];
      c.b = CUBE_LVL[3'(k % 8'd6)];
    end else if (idx < 10'd256) begin
      grey = 8'd8 + 8'd10 * (idx[7:0] - 8'd232);
      c    = '{r: grey, g: grey, b: grey};
    end
    return c;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Palette storage: one write port, one read port, read-first on address collision.
// Latency: 1 cycle from raddr_i to rdata_o.
// Backpressure: none; accepts a write and a read every cycle.
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
module palette_ram #(
  parameter int AW = 8,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [(1 << AW)];
  logic [DW-1:0] rdata_q;

  // No reset: contents are fully rewritten by the owner after every reset.
  // The read samples the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/palette_lut.sv
// Colour palette lookup: index -> {R,G,B}, with transparency key and runtime entry writes.
// Latency: 2 cycles index-to-colour, one lookup per cycle; 2^IDX_W-cycle table load after reset.
// Backpressure: none on lookups; writes stall (wr_ready_o=0) only during table load and are dropped.
// Ports: clk/reset_n; pix_valid_i/pix_idx_i lookup in; rgb_valid_o/rgb_o/transparent_o out;
//        key_en_i/key_idx_i transparency key; wr_en_i/wr_addr_i/wr_data_i/wr_ready_o entry write;
//        init_busy_o table load status; fade_i only when PALETTE_LUT_FADE_EN is defined.
module palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int CH_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_valid_i,
  input  logic [IDX_W-1:0]  pix_idx_i,
  output logic [3*CH_W-1:0] rgb_o,
  output logic              rgb_valid_o,
  output logic              transparent_o,
  input  logic              key_en_i,
  input  logic [IDX_W-1:0]  key_idx_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_addr_i,
  input  logic [3*CH_W-1:0] wr_data_i,
  output logic              wr_ready_o,
`ifdef PALETTE_LUT_FADE_EN
  input  logic [3:0]        fade_i,
`endif
  output logic              init_busy_o
);

  // Keep the top CH_W bits of each 8-bit channel.
  function automatic logic [3*CH_W-1:0] reduce_rgb(input rgb8_t c);
    return {c.r[7 -: CH_W], c.g[7 -: CH_W], c.b[7 -: CH_W]};
  endfunction

`ifdef PALETTE_LUT_FADE_EN
  // c * (16 - f) / 16; f = 0 leaves the channel untouched.
  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] c, input logic [3:0] f);
    logic [CH_W+4:0] prod;
    prod = (CH_W+5)'(c) * (CH_W+5)'(5'd16 - {1'b0, f});
    return CH_W'(prod >> 4);
  endfunction
`endif

  palette_state_e    state_q, state_d;
  logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [3*CH_W-1:0] ram_wdata;
  logic [3*CH_W-1:0] ram_rdata;
  logic [3*CH_W-1:0] init_data;

  logic              issue;
  logic              vld_s1_q;
  logic              key_hit_s1_q;
  logic [3*CH_W-1:0] rgb_d, rgb_q;
  logic              rgb_vld_q;
  logic              transp_q;
`ifdef PALETTE_LUT_FADE_EN
  logic [3:0]        fade_s1_q;
`endif

  assign init_data = reduce_rgb(xterm_rgb8(10'(init_cnt_q)));

  // ---------------- table-load / run FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // The write port belongs to the loader during INIT and to wr_* in RUN;
  // INIT-time write requests are simply ignored.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_addr_i;
    ram_wdata  = wr_data_i;
    unique case (state_q)
      ST_INIT: begin
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_wdata  = init_data;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == {IDX_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ram_we = wr_en_i;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign wr_ready_o  = (state_q == ST_RUN);
  // Gated by reset_n so the flag reads 0 while reset is held.
  assign init_busy_o = reset_n & (state_q == ST_INIT);

  // ---------------- lookup pipeline ----------------
  assign issue = pix_valid_i & (state_q == ST_RUN);

  palette_ram #(
    .AW (IDX_W),
    .DW (3*CH_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (pix_idx_i),
    .rdata_o (ram_rdata)
  );

  // Stage 1 travels beside the RAM read; key/fade are captured at issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_s1_q     <= 1'b0;
      key_hit_s1_q <= 1'b0;
`ifdef PALETTE_LUT_FADE_EN
      fade_s1_q    <= '0;
`endif
    end else begin
      vld_s1_q     <= issue;
      key_hit_s1_q <= issue & key_en_i & (pix_idx_i == key_idx_i);
`ifdef PALETTE_LUT_FADE_EN
      fade_s1_q    <= fade_i;
`endif
    end
  end

  always_comb begin
    rgb_d = '0;
    if (vld_s1_q) begin
`ifdef PALETTE_LUT_FADE_EN
      rgb_d = {fade_ch(ram_rdata[3*CH_W-1 -: CH_W], fade_s1_q),
               fade_ch(ram_rdata[2*CH_W-1 -: CH_W], fade_s1_q),
               fade_ch(ram_rdata[CH_W-1:0],         fade_s1_q)};
`else
      rgb_d = ram_rdata;
`endif
    end
  end

  // Output stage: colour and transparency are forced to 0 on idle beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q     <= '0;
      rgb_vld_q <= 1'b0;
      transp_q  <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      rgb_vld_q <= vld_s1_q;
      transp_q  <= vld_s1_q & key_hit_s1_q;
    end
  end

  assign rgb_o         = rgb_q;
  assign rgb_valid_o   = rgb_vld_q;
  assign transparent_o = transp_q;

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut (IDX_W=8, CH_W=8) with an in-bench reference model.
module tb_palette_lut;

  localparam int IDX_W = 8;
  localparam int CH_W  = 8;
  localparam int NENT  = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              pix_valid_i;
  logic [IDX_W-1:0]  pix_idx_i;
  logic [3*CH_W-1:0] rgb_o;
  logic              rgb_valid_o;
  logic              transparent_o;
  logic              key_en_i;
  logic [IDX_W-1:0]  key_idx_i;
  logic              wr_en_i;
  logic [IDX_W-1:0]  wr_addr_i;
  logic [3*CH_W-1:0] wr_data_i;
  logic              wr_ready_o;
  logic              init_busy_o;
  logic [3:0]        fade_v;

  always #5 clk = ~clk;

  palette_lut #(.IDX_W(IDX_W), .CH_W(CH_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pix_valid_i   (pix_valid_i),
    .pix_idx_i     (pix_idx_i),
    .rgb_o         (rgb_o),
    .rgb_valid_o   (rgb_valid_o),
    .transparent_o (transparent_o),
    .key_en_i      (key_en_i),
    .key_idx_i     (key_idx_i),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .wr_ready_o    (wr_ready_o),
`ifdef PALETTE_LUT_FADE_EN
    .fade_i        (fade_v),
`endif
    .init_busy_o   (init_busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // xterm colour by its published rules, expressed independently of any table layout.
  function automatic logic [23:0] xterm(input int i);
    int lv [6] = '{0, 95, 135, 175, 215, 255};
    int r, g, b, v;
    r = 0; g = 0; b = 0;
    if (i == 7) begin
      r = 192; g = 192; b = 192;
    end else if (i == 8) begin
      r = 128; g = 128; b = 128;
    end else if (i < 8) begin
      r = (i & 1) ? 128 : 0; g = (i & 2) ? 128 : 0; b = (i & 4) ? 128 : 0;
    end else if (i < 16) begin
      r = ((i - 8) & 1) ? 255 : 0; g = ((i - 8) & 2) ? 255 : 0; b = ((i - 8) & 4) ? 255 : 0;
    end else if (i < 232) begin
      r = lv[(i - 16) / 36]; g = lv[((i - 16) / 6) % 6]; b = lv[(i - 16) % 6];
    end else if (i < 256) begin
      v = 8 + 10 * (i - 232); r = v; g = v; b = v;
    end
    r = r >> (8 - CH_W); g = g >> (8 - CH_W); b = b >> (8 - CH_W);
    return 24'((r << (2*CH_W)) | (g << CH_W) | b);
  endfunction

  function automatic logic [23:0] faded(input logic [23:0] c, input int f);
    int r, g, b;
    r = (int'(c[23:16]) * (16 - f)) / 16;
    g = (int'(c[15:8])  * (16 - f)) / 16;
    b = (int'(c[7:0])   * (16 - f)) / 16;
    return 24'((r << 16) | (g << 8) | b);
  endfunction

  logic [23:0] mem [NENT];
  int          left  = NENT;   // table-load cycles still to run
  logic        p_vld = 1'b0;   // expectation for the next output beat
  logic [23:0] p_rgb = '0;
  logic        p_tr  = 1'b0;

  always @(posedge clk) begin
    int f;
    #1;
    chk("rgb_valid", 32'(rgb_valid_o),   reset_n ? 32'(p_vld) : 32'd0);
    chk("rgb",       32'(rgb_o),         reset_n ? 32'(p_rgb) : 32'd0);
    chk("transp",    32'(transparent_o), reset_n ? 32'(p_tr)  : 32'd0);
    if (!reset_n) begin
      left = NENT; p_vld = 0; p_rgb = 0; p_tr = 0;
      for (int i = 0; i < NENT; i++) mem[i] = xterm(i);
    end else if (left > 0) begin
      left--; p_vld = 0; p_rgb = 0; p_tr = 0;
    end else begin
`ifdef PALETTE_LUT_FADE_EN
      f = int'(fade_v);
`else
      f = 0;
`endif
      p_vld = pix_valid_i;
      p_rgb = pix_valid_i ? faded(mem[pix_idx_i], f) : 24'd0;
      p_tr  = pix_valid_i && key_en_i && (pix_idx_i == key_idx_i);
      if (wr_en_i) mem[wr_addr_i] = wr_data_i;
    end
    chk("init_busy", 32'(init_busy_o), 32'(reset_n && left > 0));
    chk("wr_ready",  32'(wr_ready_o),  32'(reset_n && left == 0));
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    pix_valid_i = 0; pix_idx_i = '0; wr_en_i = 0; wr_addr_i = '0; wr_data_i = '0;
    key_en_i = 0; key_idx_i = '0; fade_v = '0;
  endtask

  task automatic rand_inputs();
    pix_valid_i = 1'($urandom_range(0, 1));
    pix_idx_i   = IDX_W'($urandom);
    wr_en_i     = ($urandom_range(0, 3) == 0);
    wr_addr_i   = IDX_W'($urandom);
    wr_data_i   = 24'($urandom);
    key_en_i    = 1'($urandom_range(0, 1));
    key_idx_i   = IDX_W'($urandom_range(0, 3) == 0 ? pix_idx_i : $urandom);
`ifdef PALETTE_LUT_FADE_EN
    fade_v      = 4'($urandom);
`endif
  endtask

  task automatic assert_reset(input string tag);
    @(negedge clk);
    reset_n = 0;
    #1;
    chk({tag, "_valid0"}, 32'(rgb_valid_o), 32'd0);
    chk({tag, "_rgb0"},   32'(rgb_o),       32'd0);
    chk({tag, "_tr0"},    32'(transparent_o), 32'd0);
    chk({tag, "_busy0"},  32'(init_busy_o), 32'd0);
    chk({tag, "_rdy0"},   32'(wr_ready_o),  32'd0);
    idle();
    repeat (2) @(negedge clk);
  endtask

  // Release reset and count cycles with init_busy_o high; random traffic is dropped meanwhile.
  task automatic release_and_count(input string tag);
    int n;
    @(negedge clk);
    reset_n = 1;
    #1;
    n = 0;
    while (init_busy_o && n < 2000) begin
      rand_inputs();
      @(negedge clk);
      n++;
    end
    idle();
    chk({tag, "_busy_cycles"}, 32'(n), 32'(NENT));
  endtask

  task automatic lookup_check(input logic [IDX_W-1:0] idx, input logic [23:0] exp_rgb,
                              input logic exp_tr, input string tag);
    @(negedge clk);
    pix_valid_i = 1; pix_idx_i = idx;
    @(negedge clk);
    pix_valid_i = 0;
    @(posedge clk);
    #2;
    chk({tag, "_vld"}, 32'(rgb_valid_o),   32'd1);
    chk({tag, "_rgb"}, 32'(rgb_o),         32'(exp_rgb));
    chk({tag, "_tr"},  32'(transparent_o), 32'(exp_tr));
  endtask

  task automatic stream_all();
    for (int i = 0; i < NENT; i++) begin
      @(negedge clk);
      pix_valid_i = 1; pix_idx_i = IDX_W'(i);
    end
    @(negedge clk);
    pix_valid_i = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    idle();
    reset_n = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(rgb_valid_o), 32'd0);
    chk("rst_rgb",   32'(rgb_o),       32'd0);
    chk("rst_busy",  32'(init_busy_o), 32'd0);
    chk("rst_rdy",   32'(wr_ready_o),  32'd0);

    release_and_count("boot");
    lookup_check(8'd196, 24'hff0000, 1'b0, "idx196");
    lookup_check(8'd255, 24'heeeeee, 1'b0, "idx255");
    lookup_check(8'd0,   24'h000000, 1'b0, "idx0");
    lookup_check(8'd7,   24'hc0c0c0, 1'b0, "idx7");

    // Same-cycle write and read of entry 5: old value first, new value next beat.
    @(negedge clk);
    wr_en_i = 1; wr_addr_i = 8'd5; wr_data_i = 24'h123456;
    pix_valid_i = 1; pix_idx_i = 8'd5;
    @(negedge clk);
    wr_en_i = 0;
    @(posedge clk);
    #2;
    chk("rf_old", 32'(rgb_o), 32'h800080);
    @(negedge clk);
    pix_valid_i = 0;
    @(posedge clk);
    #2;
    chk("rf_new", 32'(rgb_o), 32'h123456);
    @(negedge clk);
    wr_en_i = 1; wr_addr_i = 8'd5; wr_data_i = 24'h800080;
    @(negedge clk);
    wr_en_i = 0;

    // Transparency key.
    key_en_i = 1; key_idx_i = 8'd16;
    lookup_check(8'd16, 24'h000000, 1'b1, "key_hit");
    lookup_check(8'd17, 24'h00005f, 1'b0, "key_miss");
    stream_all();
    key_en_i = 0;
    lookup_check(8'd16, 24'h000000, 1'b0, "key_off");

`ifdef PALETTE_LUT_FADE_EN
    fade_v = 4'd8;
    lookup_check(8'd15, 24'h7f7f7f, 1'b0, "fade8");
    fade_v = 4'd0;
    lookup_check(8'd15, 24'hffffff, 1'b0, "fade0");
`endif

    stream_all();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rand_inputs();
    end
    idle();

    // Reset during table load, at load count 100.
    assert_reset("rst_a");
    @(negedge clk);
    reset_n = 1;
    repeat (100) begin
      rand_inputs();
      @(negedge clk);
    end
    reset_n = 0;
    #1;
    chk("midinit_busy0", 32'(init_busy_o), 32'd0);
    chk("midinit_vld0",  32'(rgb_valid_o), 32'd0);
    idle();
    repeat (2) @(negedge clk);
    release_and_count("reinit");
    stream_all();

    // Reset in the middle of a lookup stream.
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rand_inputs();
      pix_valid_i = 1;
    end
    assert_reset("rst_b");
    release_and_count("restream");
    lookup_check(8'd196, 24'hff0000, 1'b0, "post_idx196");
    stream_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
